// File: rtl/keypad_lock_ctrl.sv
// Keypad door-lock controller: buffered code entry, retry lockout,
// idle auto-relock and in-field code programming.
module keypad_lock_ctrl #(
  parameter int DIGIT_W     = 4,
  parameter int CODE_LEN    = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCKOUT_CYC = 16,
  parameter int RELOCK_CYC  = 32,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               enter,
  input  logic               clear,
  input  logic               lock_cmd,
  input  logic               prog_en,
  output logic               unlocked,
  output logic               lockout,
  output logic               prog_mode,
  output logic               code_updated,
  output logic [3:0]         fail_cnt,
  output logic [3:0]         digit_cnt
);
  localparam int CODE_W = CODE_LEN * DIGIT_W;
  localparam int LO_W   = $clog2(LOCKOUT_CYC + 1);
  localparam int RL_W   = $clog2(RELOCK_CYC + 1);
  localparam logic [3:0]      LEN_C   = 4'(CODE_LEN);
  localparam logic [3:0]      OVF_C   = 4'(CODE_LEN + 1);
  localparam logic [3:0]      TRIES_C = 4'(MAX_TRIES);
  localparam logic [LO_W-1:0] LO_LOAD = LO_W'(LOCKOUT_CYC);
  localparam logic [RL_W-1:0] RL_LOAD = RL_W'(RELOCK_CYC);

  typedef enum logic [1:0] {S_LOCKED, S_UNLOCKED, S_LOCKOUT, S_PROGRAM} state_e;

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] buf_q, buf_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        fail_q, fail_d;
  logic [RL_W-1:0]   rl_q, rl_d;
  logic [LO_W-1:0]   lo_q, lo_d;
  logic              unlocked_q, unlocked_d;
  logic              lockout_q, lockout_d;
  logic              prog_q, prog_d;
  logic              upd_q, upd_d;

  logic [CODE_W-1:0] sh_buf;
  logic [3:0]        sh_cnt, fail_inc;
  logic              code_ok, to_locked;

  // Digits beyond CODE_LEN only flag overflow; the buffer keeps the first CODE_LEN.
  always_comb begin
    if (cnt_q < LEN_C) begin
      sh_buf = (buf_q << DIGIT_W) | CODE_W'(digit);
      sh_cnt = cnt_q + 4'd1;
    end else begin
      sh_buf = buf_q;
      sh_cnt = OVF_C;
    end
  end

  assign code_ok  = (cnt_q == LEN_C) && (buf_q == code_q);
  assign fail_inc = fail_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    fail_d    = fail_q;
    rl_d      = rl_q;
    lo_d      = lo_q;
    upd_d     = 1'b0;
    to_locked = 1'b0;
    case (state_q)
      S_LOCKED: begin
        // lock_cmd has no effect here but still masks the lower-priority events
        if (!lock_cmd) begin
          if (clear) begin
            buf_d = '0;
            cnt_d = '0;
          end else if (enter) begin
            buf_d = '0;
            cnt_d = '0;
            if (code_ok) begin
              state_d = S_UNLOCKED;
              fail_d  = '0;
              rl_d    = RL_LOAD;
            end else begin
              fail_d = fail_inc;
              if (fail_inc == TRIES_C) begin
                state_d = S_LOCKOUT;
                lo_d    = LO_LOAD;
              end
            end
          end else if (digit_valid) begin
            buf_d = sh_buf;
            cnt_d = sh_cnt;
          end
        end
      end
      S_UNLOCKED: begin
        if (lock_cmd) begin
          to_locked = 1'b1;
        end else if (!clear && (enter || digit_valid)) begin
          rl_d = RL_LOAD;
        end else if (!clear && prog_en) begin
          state_d = S_PROGRAM;
          buf_d   = '0;
          cnt_d   = '0;
          rl_d    = RL_LOAD;
        end else if (rl_q <= RL_W'(1)) begin
          to_locked = 1'b1;
        end else begin
          rl_d = rl_q - RL_W'(1);
        end
      end
      S_LOCKOUT: begin
        if (lo_q <= LO_W'(1)) begin
          state_d = S_LOCKED;
          fail_d  = '0;
          lo_d    = '0;
        end else begin
          lo_d = lo_q - LO_W'(1);
        end
      end
      S_PROGRAM: begin
        if (lock_cmd) begin
          to_locked = 1'b1;
        end else if (clear) begin
          buf_d = '0;
          cnt_d = '0;
        end else if (enter) begin
          if (cnt_q == LEN_C) begin
            code_d = buf_q;
            upd_d  = 1'b1;
          end
          state_d = S_UNLOCKED;
          buf_d   = '0;
          cnt_d   = '0;
          rl_d    = RL_LOAD;
        end else if (digit_valid) begin
          buf_d = sh_buf;
          cnt_d = sh_cnt;
        end
      end
      default: to_locked = 1'b1;
    endcase
    if (to_locked) begin
      state_d = S_LOCKED;
      buf_d   = '0;
      cnt_d   = '0;
      rl_d    = '0;
    end
    unlocked_d = (state_d == S_UNLOCKED) || (state_d == S_PROGRAM);
    lockout_d  = (state_d == S_LOCKOUT);
    prog_d     = (state_d == S_PROGRAM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_LOCKED;
      code_q     <= DEFAULT_CODE;
      buf_q      <= '0;
      cnt_q      <= '0;
      fail_q     <= '0;
      rl_q       <= '0;
      lo_q       <= '0;
      unlocked_q <= 1'b0;
      lockout_q  <= 1'b0;
      prog_q     <= 1'b0;
      upd_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      fail_q     <= fail_d;
      rl_q       <= rl_d;
      lo_q       <= lo_d;
      unlocked_q <= unlocked_d;
      lockout_q  <= lockout_d;
      prog_q     <= prog_d;
      upd_q      <= upd_d;
    end
  end

  assign unlocked     = unlocked_q;
  assign lockout      = lockout_q;
  assign prog_mode    = prog_q;
  assign code_updated = upd_q;
  assign fail_cnt     = fail_q;
  assign digit_cnt    = cnt_q;
endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Randomized + directed bench for keypad_lock_ctrl against a deadline-based
// behavioural model of the lock.
module tb_keypad_lock_ctrl;
  localparam int W = 4, L = 4, TRIES = 3, LOCKOUT = 16, RELOCK = 32;
  localparam int CW = W * L;

  logic clk = 1'b0, reset = 1'b1;
  logic digit_valid, enter, clear, lock_cmd, prog_en;
  logic [W-1:0] digit;
  logic unlocked, lockout, prog_mode, code_updated;
  logic [3:0] fail_cnt, digit_cnt;

  keypad_lock_ctrl #(.DIGIT_W(W), .CODE_LEN(L), .MAX_TRIES(TRIES),
    .LOCKOUT_CYC(LOCKOUT), .RELOCK_CYC(RELOCK), .DEFAULT_CODE(16'h1234)) dut (
    .clk(clk), .reset(reset), .digit_valid(digit_valid), .digit(digit),
    .enter(enter), .clear(clear), .lock_cmd(lock_cmd), .prog_en(prog_en),
    .unlocked(unlocked), .lockout(lockout), .prog_mode(prog_mode),
    .code_updated(code_updated), .fail_cnt(fail_cnt), .digit_cnt(digit_cnt));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit cmp_en = 1'b0;

  // model: mode flags, entered digits, stored code, timers as absolute deadlines
  bit m_unl, m_prog, m_lockout, m_upd;
  int m_fails, n, rl_end, lo_end;
  int ent[$];
  logic [CW-1:0] m_code;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] ent_val();
    logic [CW-1:0] v = '0;
    for (int i = 0; i < L; i++) v = (v << W) | CW'(ent[i]);
    return v;
  endfunction

  task automatic model_reset();
    m_unl = 0; m_prog = 0; m_lockout = 0; m_upd = 0; m_fails = 0;
    m_code = 16'h1234; ent.delete(); n = 0; rl_end = 0; lo_end = 0;
  endtask

  task automatic model_step();
    n++;
    m_upd = 0;
    if (m_lockout) begin
      if (n == lo_end) begin m_lockout = 0; m_fails = 0; end
    end else if (lock_cmd) begin
      if (m_unl) begin m_unl = 0; m_prog = 0; ent.delete(); end
    end else if (clear) begin
      ent.delete();
      if (m_unl && !m_prog && n == rl_end) m_unl = 0;
    end else if (enter) begin
      if (m_prog) begin
        if (ent.size() == L) begin m_code = ent_val(); m_upd = 1; end
        m_prog = 0;
        rl_end = n + RELOCK;
      end else if (m_unl) begin
        rl_end = n + RELOCK;
      end else if (ent.size() == L && ent_val() == m_code) begin
        m_unl = 1; m_fails = 0; rl_end = n + RELOCK;
      end else begin
        m_fails++;
        if (m_fails == TRIES) begin m_lockout = 1; lo_end = n + LOCKOUT; end
      end
      ent.delete();
    end else if (digit_valid) begin
      if (m_unl && !m_prog) rl_end = n + RELOCK;
      else if (ent.size() <= L) ent.push_back(int'(digit));
    end else if (prog_en && m_unl && !m_prog) begin
      m_prog = 1;
      ent.delete();
    end else if (m_unl && !m_prog && n == rl_end) begin
      m_unl = 0;
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("unlocked", unlocked, m_unl);
      chk("lockout", lockout, m_lockout);
      chk("prog_mode", prog_mode, m_prog);
      chk("code_updated", code_updated, m_upd);
      chk("fail_cnt", fail_cnt, m_fails);
      chk("digit_cnt", digit_cnt, ent.size());
    end
  end

  task automatic cyc(input logic dv, input logic [W-1:0] d, input logic en,
                     input logic cl, input logic lk, input logic pg);
    digit_valid = dv; digit = d; enter = en; clear = cl; lock_cmd = lk; prog_en = pg;
    @(posedge clk);
    model_step();
    @(negedge clk);
    digit_valid = 0; digit = '0; enter = 0; clear = 0; lock_cmd = 0; prog_en = 0;
  endtask

  task automatic key(input logic [W-1:0] d);  cyc(1, d, 0, 0, 0, 0); endtask
  task automatic idle();                      cyc(0, '0, 0, 0, 0, 0); endtask
  task automatic press_enter();               cyc(0, '0, 1, 0, 0, 0); endtask
  task automatic code4(input logic [15:0] c);
    for (int i = 0; i < 4; i++) key(c[15-4*i -: 4]);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_unl"}, unlocked, 0);
    chk({nm, "_lko"}, lockout, 0);
    chk({nm, "_prg"}, prog_mode, 0);
    chk({nm, "_upd"}, code_updated, 0);
    chk({nm, "_fail"}, fail_cnt, 0);
    chk({nm, "_dcnt"}, digit_cnt, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int cnt, r, idx;
    logic dv, en, cl, lk, pg;
    logic [W-1:0] d;
    digit_valid = 0; digit = '0; enter = 0; clear = 0; lock_cmd = 0; prog_en = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    cmp_en = 1;
    reset = 0;

    code4(16'h1234); press_enter();
    chk("unlock_basic", unlocked, 1);
    chk("unlock_fail0", fail_cnt, 0);
    chk("unlock_dcnt0", digit_cnt, 0);

    cnt = 1;
    for (int i = 0; i < 200 && unlocked; i++) begin idle(); if (unlocked) cnt++; end
    chk("relock_len", cnt, 32);

    code4(16'h1234); press_enter();
    cnt = 1;
    repeat (19) begin idle(); if (unlocked) cnt++; end
    key(4'd7); if (unlocked) cnt++;
    for (int i = 0; i < 200 && unlocked; i++) begin idle(); if (unlocked) cnt++; end
    chk("relock_reload_len", cnt, 52);

    for (int t = 0; t < 3; t++) begin
      code4(16'h1235); press_enter();
      if (t < 2) chk("wrong_fail_cnt", fail_cnt, t + 1);
    end
    chk("lockout_set", lockout, 1);
    cnt = 1;
    for (int i = 0; i < 4; i++) begin key(4'(i + 1)); if (lockout) cnt++; end
    press_enter(); if (lockout) cnt++;
    for (int i = 0; i < 200 && lockout; i++) begin idle(); if (lockout) cnt++; end
    chk("lockout_len", cnt, 16);
    chk("lockout_ignored", unlocked, 0);
    chk("lockout_fail_clr", fail_cnt, 0);

    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd4);
    chk("overflow_dcnt", digit_cnt, 5);
    press_enter();
    chk("overflow_fail", fail_cnt, 1);
    key(4'd1); key(4'd2);
    cyc(0, '0, 1, 1, 0, 0);
    chk("clear_enter_dcnt", digit_cnt, 0);
    chk("clear_enter_fail", fail_cnt, 1);

    code4(16'h1234); press_enter();
    cyc(0, '0, 0, 0, 0, 1);
    chk("prog_enter", prog_mode, 1);
    code4(16'h9876); press_enter();
    chk("prog_upd", code_updated, 1);
    chk("prog_unl", unlocked, 1);
    chk("prog_exit", prog_mode, 0);
    idle();
    chk("prog_upd_pulse", code_updated, 0);
    cyc(0, '0, 0, 0, 1, 0);
    chk("lock_cmd", unlocked, 0);
    code4(16'h1234); press_enter();
    chk("old_code_fail", fail_cnt, 1);
    chk("old_code_locked", unlocked, 0);
    code4(16'h9876); press_enter();
    chk("new_code_unl", unlocked, 1);

    cyc(0, '0, 0, 0, 0, 1);
    key(4'd5); key(4'd6);
    #2 reset = 1;
    model_reset();
    #1 chk_all_zero("midreset");
    @(negedge clk);
    reset = 0;
    code4(16'h9876); press_enter();
    chk("reset_code_gone", unlocked, 0);
    code4(16'h1234); press_enter();
    chk("reset_default_code", unlocked, 1);

    for (int k = 0; k < 3000; k++) begin
      dv = 0; en = 0; cl = 0; lk = 0; pg = 0;
      r = $urandom_range(0, 99);
      idx = (ent.size() < L) ? ent.size() : L - 1;
      d = ($urandom_range(0, 9) < 8) ? m_code[W*(L-1-idx) +: W] : W'($urandom_range(0, 15));
      if (r < 3) lk = 1;
      else if (r < 7) cl = 1;
      else if (r < 22) en = 1;
      else if (r < 70) dv = 1;
      else if (r < 75) pg = 1;
      if ($urandom_range(0, 9) == 0) begin
        lk = lk | ($urandom_range(0, 3) == 0);
        cl = cl | ($urandom_range(0, 1) == 0);
        en = en | ($urandom_range(0, 1) == 0);
        dv = dv | ($urandom_range(0, 1) == 0);
        pg = pg | ($urandom_range(0, 1) == 0);
      end
      cyc(dv, d, en, cl, lk, pg);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_lock_ctrl.md
KEYPAD_LOCK_CTRL -- requirements
Module: keypad_lock_ctrl

Interface
REQ-001 Parameter DIGIT_W, 4, bits per keypad digit.
REQ-002 Parameter CODE_LEN, 4, digits per code (1..8).
REQ-003 Parameter MAX_TRIES, 3, consecutive failed entries that force lockout (1..15).
REQ-004 Parameter LOCKOUT_CYC, 16, lockout duration in clk cycles (>=1).
REQ-005 Parameter RELOCK_CYC, 32, idle cycles in UNLOCKED before auto-relock (>=1).
REQ-006 Parameter DEFAULT_CODE, 16'h1234, CODE_LEN*DIGIT_W-bit code loaded at reset; first-entered digit is the MS digit.
REQ-007 clk  input  1  clock; all logic on the rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 digit_valid  input  1  single-cycle strobe; digit is valid.
REQ-010 digit  input  DIGIT_W  keypad digit value.
REQ-011 enter  input  1  single-cycle strobe; submit buffered entry.
REQ-012 clear  input  1  discard buffered entry.
REQ-013 lock_cmd  input  1  request immediate lock.
REQ-014 prog_en  input  1  request code-programming mode (honoured only in UNLOCKED).
REQ-015 unlocked  output  1  high while state is UNLOCKED or PROGRAM.
REQ-016 lockout  output  1  high while state is LOCKOUT.
REQ-017 prog_mode  output  1  high while state is PROGRAM.
REQ-018 code_updated  output  1  one-cycle pulse when a new code is stored.
REQ-019 fail_cnt  output  4  consecutive failed entries since last success/lockout.
REQ-020 digit_cnt  output  4  digits currently buffered, saturating at CODE_LEN+1.

Function
REQ-021 FSM states SHALL be LOCKED, UNLOCKED, LOCKOUT and PROGRAM; all outputs are registered and reflect an input event on the first rising edge after it.
REQ-022 In LOCKED or PROGRAM, digit_valid SHALL shift digit into the entry buffer and increment digit_cnt; digits past CODE_LEN SHALL set digit_cnt to CODE_LEN+1 (overflow) and not alter the buffer.
REQ-023 Priority within a cycle SHALL be: lock_cmd > clear > enter > digit_valid; a lower-priority event in the same cycle is discarded.
REQ-024 clear SHALL empty the buffer (digit_cnt=0) and leave the state unchanged.
REQ-025 enter in LOCKED with digit_cnt==CODE_LEN and buffer==stored code SHALL move to UNLOCKED, set fail_cnt=0, load the relock timer with RELOCK_CYC.
REQ-026 Any other enter in LOCKED (wrong code, short entry, overflow, empty) SHALL count as a failure: fail_cnt increments; if the new value equals MAX_TRIES, move to LOCKOUT and load the lockout timer with LOCKOUT_CYC.
REQ-027 Every enter, successful or not, SHALL empty the buffer.
REQ-028 In LOCKOUT all inputs except reset SHALL be ignored; lockout stays high for exactly LOCKOUT_CYC cycles, then state returns to LOCKED with fail_cnt=0.
REQ-029 In UNLOCKED the relock timer SHALL decrement each cycle and reload on any digit_valid, enter or prog_en; at expiry or on lock_cmd state moves to LOCKED.
REQ-030 prog_en in UNLOCKED SHALL move to PROGRAM with an empty buffer; the relock timer is frozen in PROGRAM.
REQ-031 enter in PROGRAM with digit_cnt==CODE_LEN SHALL store the buffer as the new code, pulse code_updated, and return to UNLOCKED with timer reloaded.
REQ-032 enter in PROGRAM with any other digit_cnt SHALL return to UNLOCKED with the stored code unchanged and no code_updated pulse; fail_cnt is not affected.
REQ-033 lock_cmd in PROGRAM SHALL move to LOCKED without changing the stored code; lock_cmd in LOCKED or LOCKOUT has no effect.
REQ-034 The stored code SHALL change only per REQ-031 or reset.

Reset
REQ-035 reset SHALL asynchronously force state LOCKED, stored code DEFAULT_CODE, empty buffer, both timers 0, and unlocked=lockout=prog_mode=code_updated=0, fail_cnt=0, digit_cnt=0.
REQ-036 reset asserted mid-entry, mid-lockout or in PROGRAM SHALL discard all progress, including any unstored new code.

Verification
REQ-037 Digits 1,2,3,4 then enter -> unlocked=1 next cycle, fail_cnt=0, digit_cnt=0.
REQ-038 Three entries of 1,2,3,5+enter -> fail_cnt 1,2 then lockout=1 for exactly 16 cycles; correct code during lockout ignored; then LOCKED, fail_cnt=0.
REQ-039 Unlock, no activity -> unlocked falls after 32 cycles; repeat with a digit_valid at cycle 20 -> unlocked lasts 20+32 cycles.
REQ-040 Unlock, prog_en, digits 9,8,7,6, enter -> code_updated one pulse, unlocked=1; lock_cmd; 1,2,3,4+enter fails (fail_cnt=1); 9,8,7,6+enter unlocks.
REQ-041 Five digits 1,2,3,4,4 then enter -> digit_cnt=5 before enter, failure counted; clear+enter same cycle -> buffer emptied, no failure counted.
REQ-042 Reset asserted in PROGRAM after 2 digits -> immediate LOCKED, code reverts to 16'h1234, all outputs 0.
